// File: rtl/exu_cdb_obuf_pkg.sv
// Shared execution-unit package: default tag/id widths and the result entry
// that an execution unit hands to the common data bus.
package exu_cdb_obuf_pkg;

    localparam int EXU_TAG_W  = 7;
    localparam int EXU_ID_W   = 6;
    localparam int EXU_DATA_W = 32;

    // Result entry at the default widths; parameterised users build the same
    // layout locally from their own TAG_W/ID_W.
    typedef struct packed {
        logic [EXU_TAG_W-1:0]  tag;
        logic [EXU_DATA_W-1:0] wdata;
        logic [EXU_ID_W-1:0]   inst_id;
    } res_entry_t;

    // True when n is a power of two and at least 2 (legal buffer depth).
    function automatic logic is_pow2_depth(input int n);
        return (n >= 2) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/exu2cdb_itf.sv
// Execution-unit to CDB-arbiter handshake. The transmitter raises req from
// registered state; the arbiter answers with rdy, which may depend on req.
interface exu2cdb_itf #(
    parameter int TAG_W = exu_cdb_obuf_pkg::EXU_TAG_W,
    parameter int ID_W  = exu_cdb_obuf_pkg::EXU_ID_W
);
    logic             req;
    logic             rdy;
    logic [TAG_W-1:0] tag;
    logic [31:0]      wdata;
    logic [ID_W-1:0]  inst_id;

    modport exu (output req, output tag, output wdata, output inst_id, input rdy);
    modport cdb (input req, input tag, input wdata, input inst_id, output rdy);
endinterface

// File: rtl/exu_cdb_obuf_sync_fifo.sv
// Generic synchronous FIFO storage: entry array plus wrapping read/write
// pointers. Occupancy and handshake policy belong to the wrapper; push and pop
// must only be asserted when legal. clr squashes the pointers like reset.
module sync_fifo #(
    parameter type T     = logic,
    parameter int  DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic push,
    input  logic pop,
    input  T     din,
    output T     dout
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    T                 mem_r [DEPTH];

    // Pointer update; pointers wrap naturally modulo DEPTH (power of two).
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (push) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
        end
    end

    // Entry storage: plain registers, no reset needed since occupancy gates use.
    always_ff @(posedge clk) begin
        if (push && !clr) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    assign dout = mem_r[rd_ptr_r];

endmodule

// File: rtl/exu_cdb_obuf.sv
// Execution-unit result buffer in front of the CDB arbiter. Results are queued
// in order and offered on the CDB; req and res_rdy come purely from registered
// occupancy so neither side sees a combinational path from the other.
module exu_cdb_obuf
    import exu_cdb_obuf_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = EXU_TAG_W,
    parameter int ID_W  = EXU_ID_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   res_vld,
    output logic                   res_rdy,
    input  logic [TAG_W-1:0]       res_tag,
    input  logic [31:0]            res_wdata,
    input  logic [ID_W-1:0]        res_inst_id,
    exu2cdb_itf.exu                cdb_itf,
    output logic [$clog2(DEPTH):0] occ
);

    localparam int OCC_W = $clog2(DEPTH) + 1;
    localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(DEPTH);

    // Same layout as the package entry, sized by this instance's parameters.
    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [31:0]      wdata;
        logic [ID_W-1:0]  inst_id;
    } entry_t;

    logic [OCC_W-1:0] occ_r;
    logic [OCC_W-1:0] occ_nxt_s;
    logic             push_s;
    logic             pop_s;
    logic             req_s;
    entry_t           din_s;
    entry_t           head_s;

    // Handshake flags are decoded from registered occupancy only. A full buffer
    // refuses a push even if it pops this cycle; the producer simply retries.
    assign res_rdy = (occ_r != FULL_OCC);
    assign req_s   = (occ_r != OCC_W'(0));
    assign push_s  = res_vld && res_rdy && !flush;
    assign pop_s   = req_s && cdb_itf.rdy && !flush;

    assign din_s.tag     = res_tag;
    assign din_s.wdata   = res_wdata;
    assign din_s.inst_id = res_inst_id;

    sync_fifo #(
        .T     (entry_t),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .clr  (flush),
        .push (push_s),
        .pop  (pop_s),
        .din  (din_s),
        .dout (head_s)
    );

    // Next occupancy: flush wins, otherwise occ + push - pop.
    always_comb begin
        occ_nxt_s = occ_r;
        if (flush) begin
            occ_nxt_s = '0;
        end else begin
            case ({push_s, pop_s})
                2'b10:   occ_nxt_s = occ_r + OCC_W'(1);
                2'b01:   occ_nxt_s = occ_r - OCC_W'(1);
                default: occ_nxt_s = occ_r;
            endcase
        end
    end

    // Occupancy register.
    always_ff @(posedge clk) begin
        if (rst) begin
            occ_r <= '0;
        end else begin
            occ_r <= occ_nxt_s;
        end
    end

    // Head entry is held stable until popped because only a pop moves rd_ptr.
    assign cdb_itf.req     = req_s;
    assign cdb_itf.tag     = head_s.tag;
    assign cdb_itf.wdata   = head_s.wdata;
    assign cdb_itf.inst_id = head_s.inst_id;
    assign occ             = occ_r;

endmodule

// File: tb/tb_exu_cdb_obuf.sv
// Self-checking bench for exu_cdb_obuf: a scoreboard queue models the FIFO,
// every cycle checks occ/req/res_rdy against it and every CDB transfer
// against the queue head.
module tb_exu_cdb_obuf;
    import exu_cdb_obuf_pkg::*;

    localparam int DEPTH = 4;
    localparam int TAG_W = EXU_TAG_W;
    localparam int ID_W  = EXU_ID_W;

    logic                   clk;
    logic                   rst;
    logic                   flush;
    logic                   res_vld;
    logic                   res_rdy;
    logic [TAG_W-1:0]       res_tag;
    logic [31:0]            res_wdata;
    logic [ID_W-1:0]        res_inst_id;
    logic [$clog2(DEPTH):0] occ;
    logic                   cdb_rdy;

    exu2cdb_itf #(.TAG_W(TAG_W), .ID_W(ID_W)) cdb ();
    assign cdb.rdy = cdb_rdy;

    exu_cdb_obuf #(.DEPTH(DEPTH), .TAG_W(TAG_W), .ID_W(ID_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .res_vld     (res_vld),
        .res_rdy     (res_rdy),
        .res_tag     (res_tag),
        .res_wdata   (res_wdata),
        .res_inst_id (res_inst_id),
        .cdb_itf     (cdb),
        .occ         (occ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    res_entry_t sb[$];
    int errors = 0;
    int checks = 0;
    int n_push = 0;
    int n_pop  = 0;

    // One clock: account handshakes against the model, advance, check state.
    task automatic cycle();
        res_entry_t       e;
        logic             pr_stall;
        logic [TAG_W-1:0] pr_tag;
        logic [31:0]      pr_wdata;
        logic [ID_W-1:0]  pr_id;
        pr_stall = (cdb.req === 1'b1) && !cdb_rdy && !rst && !flush;
        pr_tag   = cdb.tag;
        pr_wdata = cdb.wdata;
        pr_id    = cdb.inst_id;
        if (rst || flush) begin
            sb.delete();
        end else begin
            if (cdb.req === 1'b1 && cdb_rdy) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL pop_unexpected: got tag=%0d, required no transfer", cdb.tag);
                end else begin
                    e = sb.pop_front();
                    n_pop++;
                    if ({cdb.tag, cdb.wdata, cdb.inst_id} !== e) begin
                        errors++;
                        $display("FAIL pop_data: got tag=%0d wdata=%h id=%0d, required tag=%0d wdata=%h id=%0d",
                                 cdb.tag, cdb.wdata, cdb.inst_id, e.tag, e.wdata, e.inst_id);
                    end
                end
            end
            if (res_vld && res_rdy === 1'b1) begin
                e.tag     = res_tag;
                e.wdata   = res_wdata;
                e.inst_id = res_inst_id;
                sb.push_back(e);
                n_push++;
            end
        end
        @(posedge clk);
        #1;
        checks += 3;
        if (occ !== ($clog2(DEPTH)+1)'(sb.size())) begin
            errors++;
            $display("FAIL occ_model: got %0d, required %0d", occ, sb.size());
        end
        if (cdb.req !== (sb.size() != 0)) begin
            errors++;
            $display("FAIL req_model: got %b, required %b", cdb.req, sb.size() != 0);
        end
        if (res_rdy !== (sb.size() != DEPTH)) begin
            errors++;
            $display("FAIL res_rdy_model: got %b, required %b", res_rdy, sb.size() != DEPTH);
        end
        if (pr_stall && !rst && !flush) begin
            checks++;
            if (cdb.req !== 1'b1 || cdb.tag !== pr_tag || cdb.wdata !== pr_wdata || cdb.inst_id !== pr_id) begin
                errors++;
                $display("FAIL stall_hold: got req=%b tag=%0d, required req=1 tag=%0d", cdb.req, cdb.tag, pr_tag);
            end
        end
    endtask

    task automatic drive_res(input logic vld, input int tag, input logic [31:0] wd, input int id);
        res_vld     = vld;
        res_tag     = TAG_W'(tag);
        res_wdata   = wd;
        res_inst_id = ID_W'(id);
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; cdb_rdy = 1'b0;
        drive_res(1'b0, 0, 32'h0, 0);
        cycle();
        cycle();
        rst = 1'b0;
        checks += 3;
        if (occ !== 3'd0) begin errors++; $display("FAIL reset_occ: got %0d, required 0", occ); end
        if (cdb.req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b, required 0", cdb.req); end
        if (res_rdy !== 1'b1) begin errors++; $display("FAIL reset_res_rdy: got %b, required 1", res_rdy); end
    endtask

    task automatic test_single();
        cdb_rdy = 1'b1;
        drive_res(1'b1, 5, 32'hDEADBEEF, 3);
        cycle();
        drive_res(1'b0, 0, 32'h0, 0);
        checks += 4;
        if (cdb.req !== 1'b1) begin errors++; $display("FAIL single_req: got %b, required 1", cdb.req); end
        if (cdb.tag !== 7'd5) begin errors++; $display("FAIL single_tag: got %0d, required 5", cdb.tag); end
        if (cdb.wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL single_wdata: got %h, required deadbeef", cdb.wdata); end
        if (cdb.inst_id !== 6'd3) begin errors++; $display("FAIL single_id: got %0d, required 3", cdb.inst_id); end
        cycle();
        checks++;
        if (cdb.req !== 1'b0) begin errors++; $display("FAIL single_req_drop: got %b, required 0", cdb.req); end
    endtask

    task automatic test_full_stall();
        cdb_rdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive_res(1'b1, 10 + i, 32'h1000 + 32'(i), i);
            cycle();
        end
        drive_res(1'b1, 99, 32'h99, 9);
        for (int i = 0; i < 10; i++) begin
            checks += 3;
            if (res_rdy !== 1'b0) begin errors++; $display("FAIL full_res_rdy: got %b, required 0", res_rdy); end
            if (occ !== 3'd4) begin errors++; $display("FAIL full_occ: got %0d, required 4", occ); end
            if (cdb.tag !== 7'd10) begin errors++; $display("FAIL full_head: got %0d, required 10", cdb.tag); end
            cycle();
        end
        cdb_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            res_vld = (i == 0);
            checks++;
            if (cdb.tag !== TAG_W'(10 + i)) begin
                errors++;
                $display("FAIL drain_order: got %0d, required %0d", cdb.tag, 10 + i);
            end
            cycle();
        end
        res_vld = 1'b0;
        checks++;
        if (occ !== 3'd0) begin errors++; $display("FAIL drain_empty: got %0d, required 0", occ); end
    endtask

    task automatic test_push_pop();
        cdb_rdy = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive_res(1'b1, 20 + i, 32'h2000 + 32'(i), 20 + i);
            cycle();
        end
        cdb_rdy = 1'b1;
        for (int i = 0; i < 9; i++) begin
            drive_res(1'b1, 22 + i, 32'h2200 + 32'(i), 22 + i);
            cycle();
            checks++;
            if (occ !== 3'd2) begin errors++; $display("FAIL pushpop_occ: got %0d, required 2", occ); end
        end
        drive_res(1'b0, 0, 32'h0, 0);
        cycle();
        cycle();
    endtask

    task automatic test_flush();
        cdb_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_res(1'b1, 40 + i, 32'h4000 + 32'(i), i);
            cycle();
        end
        flush = 1'b1; cdb_rdy = 1'b1;
        drive_res(1'b1, 43, 32'h4343, 4);
        cycle();
        flush = 1'b0;
        drive_res(1'b0, 0, 32'h0, 0);
        checks += 3;
        if (occ !== 3'd0) begin errors++; $display("FAIL flush_occ: got %0d, required 0", occ); end
        if (cdb.req !== 1'b0) begin errors++; $display("FAIL flush_req: got %b, required 0", cdb.req); end
        if (res_rdy !== 1'b1) begin errors++; $display("FAIL flush_res_rdy: got %b, required 1", res_rdy); end
        cycle();
        cycle();
    endtask

    task automatic test_random();
        int budget;
        n_push = 0;
        n_pop  = 0;
        budget = 0;
        while ((n_push < 200 || sb.size() != 0) && budget < 5000) begin
            res_vld     = (n_push < 200) && ($urandom_range(0, 3) != 0);
            res_tag     = TAG_W'(n_push);
            res_wdata   = $urandom;
            res_inst_id = ID_W'($urandom);
            cdb_rdy     = ($urandom_range(0, 1) == 1);
            cycle();
            budget++;
        end
        res_vld = 1'b0;
        checks += 2;
        if (budget >= 5000) begin errors++; $display("FAIL random_timeout: got %0d cycles, required < 5000", budget); end
        if (n_pop !== 200) begin errors++; $display("FAIL random_count: got %0d, required 200", n_pop); end
    endtask

    task automatic test_rst_mid();
        cdb_rdy = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive_res(1'b1, 60 + i, 32'h6000 + 32'(i), i);
            cycle();
        end
        drive_res(1'b0, 0, 32'h0, 0);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        checks += 3;
        if (occ !== 3'd0) begin errors++; $display("FAIL rst_mid_occ: got %0d, required 0", occ); end
        if (cdb.req !== 1'b0) begin errors++; $display("FAIL rst_mid_req: got %b, required 0", cdb.req); end
        if (res_rdy !== 1'b1) begin errors++; $display("FAIL rst_mid_res_rdy: got %b, required 1", res_rdy); end
        cdb_rdy = 1'b1;
        cycle();
    endtask

    initial begin
        test_reset();
        test_single();
        test_full_stall();
        test_push_pop();
        test_flush();
        test_random();
        test_rst_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
